alu_arbiter: RTL and testbench

//   Shares the single-cycle ALU between two requesters (req0, req1) with valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two valid/ready requesters.
// One operation in flight; IDLE -> EXEC -> RESP with registered operands and response.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_alu_control,
  input  logic [WIDTH-1:0] req0_src_a,
  input  logic [WIDTH-1:0] req0_src_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_alu_control,
  input  logic [WIDTH-1:0] req1_src_a,
  input  logic [WIDTH-1:0] req1_src_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_sign,
  output logic             rsp_overflow,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_sign,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_owner;
  logic             r_rr_fav;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_sign;
  logic             r_overflow;
  logic [2:0]       r_ctl;
  logic [WIDTH-1:0] r_src_a;
  logic [WIDTH-1:0] r_src_b;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_hs;
  logic             w_owner_ready;

  function automatic logic [1:0] owner_onehot(input logic owner);
    owner_onehot = owner ? 2'b10 : 2'b01;
  endfunction

  assign w_owner_ready = r_owner ? rsp_ready[1] : rsp_ready[0];
  assign w_accept      = req0_ready | req1_ready;

  // Tie-break: fixed priority always picks req0, otherwise the RR pointer decides.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO || !r_rr_fav) begin
        w_grant0 = 1'b1;
      end else begin
        w_grant1 = 1'b1;
      end
    end else if (req0_valid) begin
      w_grant0 = 1'b1;
    end else if (req1_valid) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    w_capture  = 1'b0;
    w_rsp_hs   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
      end
      ST_EXEC: w_capture = 1'b1;
      ST_RESP: w_rsp_hs  = w_owner_ready;
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  // Operand registers hold the last op so the ALU inputs stay quiet while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl   <= 3'd0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_ctl   <= w_grant1 ? req1_alu_control : req0_alu_control;
      r_src_a <= w_grant1 ? req1_src_a : req0_src_a;
      r_src_b <= w_grant1 ? req1_src_b : req0_src_b;
      r_owner <= w_grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 2'b00;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_sign      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid <= owner_onehot(r_owner);
      r_result    <= alu_result;
      r_zero      <= alu_zero;
      r_carry     <= alu_carry;
      r_sign      <= alu_sign;
      r_overflow  <= alu_overflow;
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 2'b00;
    end
  end

  // Pointer moves only on a completed response, toward the requester just served's peer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_fav <= 1'b0;
    end else if (w_rsp_hs && !FIXED_PRIO) begin
      r_rr_fav <= ~r_owner;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_result;
  assign rsp_zero     = r_zero;
  assign rsp_carry    = r_carry;
  assign rsp_sign     = r_sign;
  assign rsp_overflow = r_overflow;
  assign alu_control  = r_ctl;
  assign alu_src_a    = r_src_a;
  assign alu_src_b    = r_src_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share stimulus and are
// checked every cycle against a transaction-level model; ALU behaviour is modelled here.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        v0, v1;
  logic [2:0]  c0, c1;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  rr_in;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [35:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] t;
    logic [31:0] r;
    logic        c, v;
    t = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[31:0]; c = t[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: r = a;
      default: r = 32'd0;
    endcase
    return {r, (r == 32'd0), c, r[31], v};
  endfunction

  logic [1:0]  obs_rdy [2];
  logic [1:0]  obs_rspv[2];
  logic [31:0] obs_res [2];
  logic [3:0]  obs_flg [2];
  logic [2:0]  obs_ctl [2];
  logic [31:0] obs_a   [2];
  logic [31:0] obs_b   [2];

  logic        rr_r0, rr_r1, rr_z, rr_c, rr_s, rr_v;
  logic        fp_r0, fp_r1, fp_z, fp_c, fp_s, fp_v;
  logic [1:0]  rr_rspv, fp_rspv;
  logic [31:0] rr_res, fp_res, rr_aa, rr_ab, fp_aa, fp_ab;
  logic [2:0]  rr_actl, fp_actl;
  logic [35:0] rr_alu, fp_alu;

  assign rr_alu = alu_f(rr_actl, rr_aa, rr_ab);
  assign fp_alu = alu_f(fp_actl, fp_aa, fp_ab);

  alu_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rr_r0), .req0_alu_control(c0), .req0_src_a(a0), .req0_src_b(b0),
    .req1_valid(v1), .req1_ready(rr_r1), .req1_alu_control(c1), .req1_src_a(a1), .req1_src_b(b1),
    .rsp_valid(rr_rspv), .rsp_ready(rr_in), .rsp_result(rr_res),
    .rsp_zero(rr_z), .rsp_carry(rr_c), .rsp_sign(rr_s), .rsp_overflow(rr_v),
    .alu_control(rr_actl), .alu_src_a(rr_aa), .alu_src_b(rr_ab),
    .alu_result(rr_alu[35:4]), .alu_zero(rr_alu[3]), .alu_carry(rr_alu[2]),
    .alu_sign(rr_alu[1]), .alu_overflow(rr_alu[0])
  );

  alu_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(fp_r0), .req0_alu_control(c0), .req0_src_a(a0), .req0_src_b(b0),
    .req1_valid(v1), .req1_ready(fp_r1), .req1_alu_control(c1), .req1_src_a(a1), .req1_src_b(b1),
    .rsp_valid(fp_rspv), .rsp_ready(rr_in), .rsp_result(fp_res),
    .rsp_zero(fp_z), .rsp_carry(fp_c), .rsp_sign(fp_s), .rsp_overflow(fp_v),
    .alu_control(fp_actl), .alu_src_a(fp_aa), .alu_src_b(fp_ab),
    .alu_result(fp_alu[35:4]), .alu_zero(fp_alu[3]), .alu_carry(fp_alu[2]),
    .alu_sign(fp_alu[1]), .alu_overflow(fp_alu[0])
  );

  assign obs_rdy[0]  = {rr_r1, rr_r0};
  assign obs_rdy[1]  = {fp_r1, fp_r0};
  assign obs_rspv[0] = rr_rspv;
  assign obs_rspv[1] = fp_rspv;
  assign obs_res[0]  = rr_res;
  assign obs_res[1]  = fp_res;
  assign obs_flg[0]  = {rr_z, rr_c, rr_s, rr_v};
  assign obs_flg[1]  = {fp_z, fp_c, fp_s, fp_v};
  assign obs_ctl[0]  = rr_actl;
  assign obs_ctl[1]  = fp_actl;
  assign obs_a[0]    = rr_aa;
  assign obs_a[1]    = fp_aa;
  assign obs_b[0]    = rr_ab;
  assign obs_b[1]    = fp_ab;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: one op outstanding, which requester wins, which op it carried.
  bit          m_busy [2];
  int          m_age  [2];
  bit          m_owner[2];
  bit          m_fav  [2];
  logic [2:0]  m_ctl  [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  bit          is_fp  [2] = '{1'b0, 1'b1};
  logic [1:0]  acc_rr, acc_fp;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_age[i] = 0; m_owner[i] = 1'b0; m_fav[i] = 1'b0;
      m_ctl[i] = 3'd0; m_a[i] = 32'd0; m_b[i] = 32'd0;
    end
  endtask

  task automatic monitor_inst(input int i);
    logic [1:0]  er;
    logic [35:0] e;
    int          winner;
    check_val($sformatf("u%0d.alu_ctl", i), {61'd0, obs_ctl[i]}, {61'd0, m_ctl[i]});
    check_val($sformatf("u%0d.alu_a", i), {32'd0, obs_a[i]}, {32'd0, m_a[i]});
    check_val($sformatf("u%0d.alu_b", i), {32'd0, obs_b[i]}, {32'd0, m_b[i]});
    if (!m_busy[i]) begin
      winner = -1;
      if (v0 && v1)  winner = is_fp[i] ? 0 : int'(m_fav[i]);
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
      er = (winner < 0) ? 2'b00 : 2'(1 << winner);
      check_val($sformatf("u%0d.ready_idle", i), {62'd0, obs_rdy[i]}, {62'd0, er});
      check_val($sformatf("u%0d.rspv_idle", i), {62'd0, obs_rspv[i]}, 64'd0);
      if (winner >= 0) begin
        m_busy[i] = 1'b1; m_age[i] = 0; m_owner[i] = (winner == 1);
        m_ctl[i] = (winner == 1) ? c1 : c0;
        m_a[i]   = (winner == 1) ? a1 : a0;
        m_b[i]   = (winner == 1) ? b1 : b0;
      end
    end else begin
      m_age[i]++;
      check_val($sformatf("u%0d.ready_busy", i), {62'd0, obs_rdy[i]}, 64'd0);
      if (m_age[i] == 1) begin
        check_val($sformatf("u%0d.rspv_exec", i), {62'd0, obs_rspv[i]}, 64'd0);
      end else begin
        e = alu_f(m_ctl[i], m_a[i], m_b[i]);
        check_val($sformatf("u%0d.rspv", i), {62'd0, obs_rspv[i]},
                  m_owner[i] ? 64'd2 : 64'd1);
        check_val($sformatf("u%0d.result", i), {32'd0, obs_res[i]}, {32'd0, e[35:4]});
        check_val($sformatf("u%0d.flags", i), {60'd0, obs_flg[i]}, {60'd0, e[3:0]});
        if (rr_in[m_owner[i]]) begin
          m_busy[i] = 1'b0;
          if (!is_fp[i]) m_fav[i] = !m_owner[i];
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_inst(0);
    monitor_inst(1);
    acc_rr = obs_rdy[0];
    acc_fp = obs_rdy[1];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rr_in = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("u%0d.rst_rspv", i), {62'd0, obs_rspv[i]}, 64'd0);
      check_val($sformatf("u%0d.rst_rdy", i), {62'd0, obs_rdy[i]}, 64'd0);
      check_val($sformatf("u%0d.rst_res", i), {32'd0, obs_res[i]}, 64'd0);
      check_val($sformatf("u%0d.rst_ctl", i), {61'd0, obs_ctl[i]}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    acc_rr = 2'b00;
    acc_fp = 2'b00;
  endtask

  task automatic new_op(input int r);
    logic [2:0]  op;
    logic [31:0] a, b;
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (r == 0) begin c0 = op; a0 = a; b0 = b; end
    else        begin c1 = op; a1 = a; b1 = b; end
  endtask

  int grants[$];
  int fp_r0_cnt, fp_r1_cnt;

  initial begin
    c0 = 3'd0; c1 = 3'd0; a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    model_reset();
    do_reset();

    // ADD 5+7 on req0
    v0 = 1'b1; c0 = 3'd0; a0 = 32'd5; b0 = 32'd7;
    tick();
    check_val("t1.accept", {62'd0, acc_rr}, 64'd1);
    v0 = 1'b0;
    check_val("t1.rspv_exec", {62'd0, rr_rspv}, 64'd0);
    tick();
    check_val("t1.rspv", {62'd0, rr_rspv}, 64'd1);
    check_val("t1.result", {32'd0, rr_res}, 64'd12);
    check_val("t1.zero", {63'd0, rr_z}, 64'd0);
    rr_in = 2'b01;
    tick();
    check_val("t1.rspv_clr", {62'd0, rr_rspv}, 64'd0);

    // SUB 3-3 on req1
    rr_in = 2'b00;
    v1 = 1'b1; c1 = 3'd1; a1 = 32'd3; b1 = 32'd3;
    tick();
    check_val("t2.accept", {62'd0, acc_rr}, 64'd2);
    v1 = 1'b0;
    tick();
    check_val("t2.rspv", {62'd0, rr_rspv}, 64'd2);
    check_val("t2.result", {32'd0, rr_res}, 64'd0);
    check_val("t2.zero", {63'd0, rr_z}, 64'd1);
    check_val("t2.ovf", {63'd0, rr_v}, 64'd0);
    rr_in = 2'b10;
    tick();
    check_val("t2.rspv_clr", {62'd0, rr_rspv}, 64'd0);

    // Response stall with req1 waiting
    rr_in = 2'b00;
    v0 = 1'b1; c0 = 3'd2; a0 = 32'h0000_00F0; b0 = 32'h0000_003C;
    v1 = 1'b1; c1 = 3'd3; a1 = 32'd1; b1 = 32'd2;
    tick();
    check_val("t5.accept0", {62'd0, acc_rr}, 64'd1);
    v0 = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("t5.hold_rspv", {62'd0, rr_rspv}, 64'd1);
      check_val("t5.hold_res", {32'd0, rr_res}, 64'h30);
      check_val("t5.r1_blocked", {63'd0, rr_r1}, 64'd0);
    end
    rr_in = 2'b10;
    tick();
    check_val("t5.ignore_other", {62'd0, rr_rspv}, 64'd1);
    rr_in = 2'b01;
    tick();
    check_val("t5.r1_ready", {63'd0, rr_r1}, 64'd1);
    tick();
    check_val("t5.accept1", {62'd0, acc_rr}, 64'd2);
    v1 = 1'b0; rr_in = 2'b11;
    repeat (3) tick();

    // Continuous contention: RR alternates, fixed priority starves req1
    do_reset();
    v0 = 1'b1; v1 = 1'b1; new_op(0); new_op(1); rr_in = 2'b11;
    fp_r0_cnt = 0; fp_r1_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (acc_rr[0]) begin grants.push_back(0); new_op(0); end
      if (acc_rr[1]) begin grants.push_back(1); new_op(1); end
      if (acc_fp[0]) fp_r0_cnt++;
      if (acc_fp[1]) fp_r1_cnt++;
    end
    check_val("t3.n_grants", 64'(grants.size()), 64'd4);
    for (int k = 0; k < grants.size(); k++)
      check_val($sformatf("t3.grant%0d", k), 64'(grants[k]), 64'(k % 2));
    check_val("t4.fp_r0", 64'(fp_r0_cnt), 64'd4);
    check_val("t4.fp_r1", 64'(fp_r1_cnt), 64'd0);
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) tick();

    // Reset during EXEC discards the op
    do_reset();
    v0 = 1'b1; c0 = 3'd0; a0 = 32'd9; b0 = 32'd1;
    tick();
    v0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t6.rspv_rst", {62'd0, rr_rspv}, 64'd0);
    model_reset();
    @(negedge clk);
    check_val("t6.ctl_rst", {61'd0, rr_actl}, 64'd0);
    check_val("t6.a_rst", {32'd0, rr_aa}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr_in = 2'b11;
    repeat (4) tick();
    v1 = 1'b1; c1 = 3'd5; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
    tick();
    v1 = 1'b0;
    tick();
    check_val("t6.next_rspv", {62'd0, rr_rspv}, 64'd2);
    check_val("t6.next_res", {32'd0, rr_res}, 64'd1);
    repeat (2) tick();

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if (!v0 || acc_rr[0]) begin
        v0 = ($urandom_range(0, 1) == 1);
        new_op(0);
      end else if ($urandom_range(0, 7) == 0) begin
        v0 = 1'b0;
      end
      if (!v1 || acc_rr[1]) begin
        v1 = ($urandom_range(0, 1) == 1);
        new_op(1);
      end else if ($urandom_range(0, 7) == 0) begin
        v1 = 1'b0;
      end
      rr_in = 2'($urandom_range(0, 3));
      tick();
    end
    v0 = 1'b0; v1 = 1'b0; rr_in = 2'b11;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
